// File: rtl/adb_poll_sched.sv
// ADB transaction scheduler: shares the single bus engine between host commands
// and periodic keyboard/mouse Talk R0 autopolls (issue, wait/timeout, idle gap).
module adb_poll_sched #(
  parameter logic [15:0] POLL_TICKS    = 16'd1000,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd400,
  parameter logic [7:0]  GAP_TICKS     = 8'd20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       host_req,
  input  logic [7:0] host_cmd,
  output logic       host_ack,
  output logic       host_done,
  output logic       host_err,
  input  logic [3:0] kbd_addr,
  input  logic [3:0] mouse_addr,
  input  logic       kbd_poll_en,
  input  logic       mouse_poll_en,
  input  logic       srq,
  output logic       bus_start,
  output logic [7:0] bus_cmd,
  input  logic       bus_done,
  output logic       kbd_poll_done,
  output logic       mouse_poll_done,
  output logic [1:0] grant,
  output logic       busy
);

  // state  | meaning
  // S_IDLE | bus free, arbitrate host vs pending polls every clk
  // S_WAIT | transaction issued, waiting for bus_done or timeout
  // S_GAP  | mandatory bus idle before the next issue
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

  localparam logic [1:0] G_NONE  = 2'd0;
  localparam logic [1:0] G_HOST  = 2'd1;
  localparam logic [1:0] G_KBD   = 2'd2;
  localparam logic [1:0] G_MOUSE = 2'd3;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_poll_cnt;
  logic [15:0] r_cnt;
  logic        r_kbd_pend, r_mouse_pend, r_rr;
  logic        r_host_ack, r_bus_start, r_host_done, r_host_err;
  logic        r_kbd_done, r_mouse_done;
  logic [7:0]  r_bus_cmd;
  logic [1:0]  r_grant;

  logic w_wrap, w_idle, w_kbd_req, w_mouse_req;
  logic w_issue_host, w_issue_kbd, w_issue_mouse, w_issue;
  logic w_done_ok, w_timeout, w_end;

  assign w_wrap = cen && (r_poll_cnt == POLL_TICKS - 16'd1);
  assign w_idle = (r_state == S_IDLE);
  // A wrap or srq can be served in the same clk it arrives; the enable gates the pend bit.
  assign w_kbd_req   = kbd_poll_en && (r_kbd_pend || w_wrap);
  assign w_mouse_req = mouse_poll_en && (r_mouse_pend || w_wrap || (srq && w_idle));

  always_comb begin
    w_state_nxt   = r_state;
    w_issue_host  = 1'b0;
    w_issue_kbd   = 1'b0;
    w_issue_mouse = 1'b0;
    w_done_ok     = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (host_req)
          w_issue_host = 1'b1;
        else if (w_kbd_req && (!w_mouse_req || !r_rr))
          w_issue_kbd = 1'b1;
        else if (w_mouse_req)
          w_issue_mouse = 1'b1;
        if (host_req || w_kbd_req || w_mouse_req)
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus_done) begin
          w_done_ok   = 1'b1;
          w_state_nxt = S_GAP;
        end else if (cen && (r_cnt == TIMEOUT_TICKS - 16'd1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (cen && (r_cnt == {8'd0, GAP_TICKS} - 16'd1))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_issue = w_issue_host || w_issue_kbd || w_issue_mouse;
  assign w_end   = w_done_ok || w_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll_cnt   <= 16'd0;
      r_cnt        <= 16'd0;
      r_kbd_pend   <= 1'b0;
      r_mouse_pend <= 1'b0;
      r_rr         <= 1'b0;
      r_host_ack   <= 1'b0;
      r_bus_start  <= 1'b0;
      r_host_done  <= 1'b0;
      r_host_err   <= 1'b0;
      r_kbd_done   <= 1'b0;
      r_mouse_done <= 1'b0;
      r_bus_cmd    <= 8'd0;
      r_grant      <= G_NONE;
    end else begin
      if (cen)
        r_poll_cnt <= w_wrap ? 16'd0 : r_poll_cnt + 16'd1;
      if (w_idle || (w_state_nxt != r_state))
        r_cnt <= 16'd0;
      else if (cen)
        r_cnt <= r_cnt + 16'd1;

      r_kbd_pend   <= w_kbd_req && !w_issue_kbd;
      r_mouse_pend <= w_mouse_req && !w_issue_mouse;
      if (w_issue_kbd)
        r_rr <= 1'b1;
      else if (w_issue_mouse)
        r_rr <= 1'b0;

      r_host_ack   <= w_issue_host;
      r_bus_start  <= w_issue;
      r_host_done  <= w_end && (r_grant == G_HOST);
      r_kbd_done   <= w_done_ok && (r_grant == G_KBD);
      r_mouse_done <= w_done_ok && (r_grant == G_MOUSE);
      if (w_end && (r_grant == G_HOST))
        r_host_err <= w_timeout;

      if (w_issue_host) begin
        r_bus_cmd <= host_cmd;
        r_grant   <= G_HOST;
      end else if (w_issue_kbd) begin
        r_bus_cmd <= {kbd_addr, 4'b1100};
        r_grant   <= G_KBD;
      end else if (w_issue_mouse) begin
        r_bus_cmd <= {mouse_addr, 4'b1100};
        r_grant   <= G_MOUSE;
      end else if (w_end) begin
        r_grant   <= G_NONE;
      end
    end
  end

  assign host_ack        = r_host_ack;
  assign host_done       = r_host_done;
  assign host_err        = r_host_err;
  assign bus_start       = r_bus_start;
  assign bus_cmd         = r_bus_cmd;
  assign kbd_poll_done   = r_kbd_done;
  assign mouse_poll_done = r_mouse_done;
  assign grant           = r_grant;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_adb_poll_sched.sv
// Directed bench for adb_poll_sched: issue-vector table plus timing sequences
// for autopoll rounds, round-robin, timeout, gap hold-off and async reset.
module tb_adb_poll_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cen = 1'b1;
  logic       host_req = 1'b0;
  logic [7:0] host_cmd = 8'd0;
  logic       host_ack, host_done, host_err;
  logic [3:0] kbd_addr = 4'd0;
  logic [3:0] mouse_addr = 4'd0;
  logic       kbd_poll_en = 1'b0;
  logic       mouse_poll_en = 1'b0;
  logic       srq = 1'b0;
  logic       bus_start;
  logic [7:0] bus_cmd;
  logic       bus_done = 1'b0;
  logic       kbd_poll_done, mouse_poll_done;
  logic [1:0] grant;
  logic       busy;

  int tests = 0;
  int fails = 0;

  adb_poll_sched dut (
    .clk(clk), .reset_n(reset_n), .cen(cen),
    .host_req(host_req), .host_cmd(host_cmd), .host_ack(host_ack),
    .host_done(host_done), .host_err(host_err),
    .kbd_addr(kbd_addr), .mouse_addr(mouse_addr),
    .kbd_poll_en(kbd_poll_en), .mouse_poll_en(mouse_poll_en), .srq(srq),
    .bus_start(bus_start), .bus_cmd(bus_cmd), .bus_done(bus_done),
    .kbd_poll_done(kbd_poll_done), .mouse_poll_done(mouse_poll_done),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hreq;
    logic [7:0] hcmd;
    logic       ken, men, srq;
    logic [3:0] kaddr, maddr;
    logic       e_start;
    logic [7:0] e_cmd;
    logic [1:0] e_grant;
    logic       e_ack, e_hdone, e_mdone;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Count sampled cycles until bus_start is seen (bounded).
  task automatic wait_start(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_start && n < maxc);
  endtask

  task automatic done_cycle();
    bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
  endtask

  initial begin
    int n, cnt;

    vecs[0] = '{1'b1, 8'h2B, 1'b0, 1'b0, 1'b0, 4'h2, 4'h3, 1'b1, 8'h2B, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'h2, 4'h3, 1'b1, 8'h3C, 2'd3, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h2, 4'h3, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 4'h2, 4'h3, 1'b1, 8'h5A, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 4'h2, 4'h3, 1'b1, 8'hFF, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'h2, 4'hF, 1'b1, 8'hFC, 2'd3, 1'b0, 1'b0, 1'b1};

    // Reset state, with a host request already waiting
    host_req = 1'b1; host_cmd = 8'hA5;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", bus_start, 0);
    chk("rst_cmd", bus_cmd, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ack", host_ack, 0);
    host_req = 1'b0;

    // Issue-vector table, each from a fresh reset with the timer mid-count
    for (int i = 0; i < 6; i++) begin
      host_req = 1'b0; srq = 1'b0;
      kbd_poll_en = vecs[i].ken; mouse_poll_en = vecs[i].men;
      kbd_addr = vecs[i].kaddr; mouse_addr = vecs[i].maddr;
      do_reset();
      repeat (50) @(negedge clk);
      host_req = vecs[i].hreq; host_cmd = vecs[i].hcmd; srq = vecs[i].srq;
      @(negedge clk);
      chk($sformatf("v%0d_start", i), bus_start, vecs[i].e_start);
      chk($sformatf("v%0d_cmd", i), bus_cmd, vecs[i].e_cmd);
      chk($sformatf("v%0d_grant", i), grant, vecs[i].e_grant);
      chk($sformatf("v%0d_ack", i), host_ack, vecs[i].e_ack);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_start);
      host_req = 1'b0; srq = 1'b0;
      done_cycle();
      chk($sformatf("v%0d_hdone", i), host_done, vecs[i].e_hdone);
      chk($sformatf("v%0d_mdone", i), mouse_poll_done, vecs[i].e_mdone);
      chk($sformatf("v%0d_kdone", i), kbd_poll_done, 0);
    end

    // Single keyboard autopoll, then gap length
    kbd_poll_en = 1'b1; mouse_poll_en = 1'b0; kbd_addr = 4'h2; mouse_addr = 4'h3;
    do_reset();
    wait_start(1100, n);
    chk("kp_latency", n, 1000);
    chk("kp_cmd", bus_cmd, 8'h2C);
    chk("kp_grant", grant, 2);
    done_cycle();
    chk("kp_done", kbd_poll_done, 1);
    chk("kp_grant_gap", grant, 0);
    @(negedge clk);
    chk("kp_done_width", kbd_poll_done, 0);
    n = 1;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("kp_gap_len", n, 20);

    // Round-robin over three rounds with both polls enabled
    mouse_poll_en = 1'b1;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      wait_start(1100, n);
      if (r == 0) chk("rr_first_latency", n, 1000);
      chk($sformatf("rr%0d_kbd_cmd", r), bus_cmd, 8'h2C);
      chk($sformatf("rr%0d_kbd_grant", r), grant, 2);
      done_cycle();
      chk($sformatf("rr%0d_kbd_done", r), kbd_poll_done, 1);
      wait_start(100, n);
      chk($sformatf("rr%0d_after_gap", r), n, 21);
      chk($sformatf("rr%0d_mouse_cmd", r), bus_cmd, 8'h3C);
      chk($sformatf("rr%0d_mouse_grant", r), grant, 3);
      done_cycle();
      chk($sformatf("rr%0d_mouse_done", r), mouse_poll_done, 1);
    end

    // Host request on the same clk as the poll-timer wrap
    mouse_poll_en = 1'b0;
    do_reset();
    repeat (999) @(negedge clk);
    host_req = 1'b1; host_cmd = 8'h2B;
    @(negedge clk);
    chk("hw_ack", host_ack, 1);
    chk("hw_start", bus_start, 1);
    chk("hw_cmd", bus_cmd, 8'h2B);
    chk("hw_grant", grant, 1);
    host_req = 1'b0;
    done_cycle();
    chk("hw_hdone", host_done, 1);
    chk("hw_herr", host_err, 0);
    chk("hw_kdone", kbd_poll_done, 0);
    wait_start(100, n);
    chk("hw_poll_after_gap", n, 21);
    chk("hw_poll_cmd", bus_cmd, 8'h2C);
    chk("hw_poll_grant", grant, 2);
    done_cycle();

    // Host timeout, then gap hold-off of the next host request
    kbd_poll_en = 1'b0;
    host_req = 1'b1; host_cmd = 8'h2B;
    do_reset();
    wait_start(5, n);
    chk("to_issue", n, 1);
    host_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_done && n < 500);
    chk("to_latency", n, 400);
    chk("to_err", host_err, 1);
    host_req = 1'b1; host_cmd = 8'h77;
    wait_start(100, n);
    chk("to_holdoff", n, 21);
    chk("to_next_cmd", bus_cmd, 8'h77);
    host_req = 1'b0;

    // bus_done on the same clk as the timeout: completion wins
    host_req = 1'b1; host_cmd = 8'h5A;
    do_reset();
    wait_start(5, n);
    chk("tie_issue", n, 1);
    host_req = 1'b0;
    repeat (399) @(negedge clk);
    chk("tie_no_early_done", host_done, 0);
    done_cycle();
    chk("tie_hdone", host_done, 1);
    chk("tie_herr", host_err, 0);

    // Mouse poll timeout: no done pulse, bus returns to idle
    mouse_poll_en = 1'b1; mouse_addr = 4'h3;
    srq = 1'b1;
    do_reset();
    wait_start(5, n);
    chk("pto_issue", n, 1);
    chk("pto_cmd", bus_cmd, 8'h3C);
    srq = 1'b0;
    cnt = 0;
    repeat (430) begin
      @(negedge clk);
      if (mouse_poll_done || host_done) cnt++;
    end
    chk("pto_no_done", cnt, 0);
    chk("pto_idle", busy, 0);

    // Async reset during WAIT with a mouse poll left pending
    kbd_poll_en = 1'b1; mouse_poll_en = 1'b1;
    host_req = 1'b1; host_cmd = 8'h2B; srq = 1'b1;
    do_reset();
    wait_start(5, n);
    chk("ar_issue_host", grant, 1);
    host_req = 1'b0; srq = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_grant", grant, 0);
    chk("ar_cmd", bus_cmd, 0);
    chk("ar_start", bus_start, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_start || host_done || kbd_poll_done || mouse_poll_done) cnt++;
    end
    chk("ar_quiet", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adb_poll_sched.md
Name: adb_poll_sched

Overview:
- Transaction scheduler for the ADB GLU: shares the single ADB bus engine among host commands (C026 writes) and periodic keyboard/mouse autopoll Talk R0 transactions.
- Sits between the C024–C027 register file and the bit-level ADB transceiver.
- Sequences each transaction (issue, wait, timeout, inter-transaction gap) and reports completion to the register file.

Parameters:
- POLL_TICKS, 16'd1000, cen ticks between autopoll rounds.
- TIMEOUT_TICKS, 16'd400, cen ticks allowed between bus_start and bus_done.
- GAP_TICKS, 8'd20, cen ticks of mandatory bus idle after each transaction.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cen  in  1  time-base enable; all tick counters advance only when cen=1
- host_req  in  1  host command waiting; held high until host_ack
- host_cmd  in  8  ADB command byte {addr[7:4], cmd[3:2], reg[1:0]}
- host_ack  out  1  one-clk pulse: host_cmd latched and issued
- host_done  out  1  one-clk pulse: host transaction finished
- host_err  out  1  valid with host_done; 1 = timeout
- kbd_addr  in  4  keyboard ADB address
- mouse_addr  in  4  mouse ADB address
- kbd_poll_en  in  1  keyboard autopoll enable
- mouse_poll_en  in  1  mouse autopoll enable
- srq  in  1  device service request (level)
- bus_start  out  1  one-clk pulse to transceiver
- bus_cmd  out  8  command byte; stable from bus_start until bus_done or timeout
- bus_done  in  1  one-clk pulse: transceiver finished
- kbd_poll_done  out  1  one-clk pulse: keyboard poll finished without timeout
- mouse_poll_done  out  1  one-clk pulse: mouse poll finished without timeout
- grant  out  2  current owner: 0 none, 1 host, 2 kbd, 3 mouse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; all pulses=0; bus_cmd=0, grant=0, busy=0, host_err=0.
  - Counters cleared; kbd_pend=0, mouse_pend=0; rr pointer=kbd.
- Poll timer:
  - Counts cen ticks from 0 to POLL_TICKS-1, then wraps to 0.
  - On wrap: set kbd_pend if kbd_poll_en; set mouse_pend if mouse_poll_en.
  - Already-set pend bits stay set; requests do not accumulate.
  - srq=1 in IDLE with mouse_poll_en=1 sets mouse_pend immediately.
  - Deasserting an enable clears its pend bit in the same clk.
- States:
  - IDLE, evaluated every clk (not gated by cen). Priority: host_req > pending poll.
    - Host: latch bus_cmd=host_cmd, pulse host_ack and bus_start, grant=1, go WAIT.
    - Poll: when both pend bits are set, the rr pointer chooses. bus_cmd={addr,4'b1100} (Talk R0). Clear that pend bit, toggle rr to the other device, pulse bus_start, grant=2/3, go WAIT.
    - Host and poll in the same clk: host wins; pend bits are untouched.
  - WAIT: counter cleared on entry, +1 per cen.
    - bus_done: pulse host_done (host_err=0) or the matching *_poll_done; go GAP.
    - Counter reaching TIMEOUT_TICKS before bus_done: host owner pulses host_done with host_err=1; poll owner gets no done pulse. Go GAP.
    - bus_done and the timeout in the same clk: bus_done wins.
  - GAP:
    - Counter cleared on entry; return to IDLE after GAP_TICKS cen ticks.
    - grant=0 on entry to GAP.
    - host_req and new pend bits are held off until IDLE.
- Latency:
  - bus_start is in the same clk that IDLE sees a request.
  - Done pulses come 1 clk after bus_done.
- Pulses are exactly one clk wide regardless of cen.
- bus_done received outside WAIT is ignored.
- Changes to kbd_addr/mouse_addr are sampled only at issue.
- Poll timer runs in every state, including during transactions.

Test Plan:
- Reset, kbd_poll_en=1, kbd_addr=2, no host -> after 1000 cen ticks, bus_start with bus_cmd=8'h2C, grant=2. Transceiver bus_done -> kbd_poll_done pulse; busy low 20 cen ticks later.
- Both polls enabled, mouse_addr=3 -> first round issues 8'h2C then, after the gap, 8'h3C. Next round again starts with kbd (rr alternation verified over 3 rounds).
- host_req with host_cmd=8'h2B in the same clk as the poll-timer wrap -> host_ack, bus_cmd=8'h2B, grant=1. Kbd poll issued after the GAP.
- Host command with no bus_done -> host_done with host_err=1 exactly at 400 cen ticks; GAP follows; next issue is not earlier than 20 cen ticks later.
- srq pulse in IDLE, mouse_poll_en=1, timer mid-count -> immediate Talk 8'h3C. With mouse_poll_en=0 -> no issue.
- reset_n low during WAIT -> outputs zero asynchronously; after release, no done pulse for the aborted transaction and pend bits are clear.
